// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner.
package btn_pkg;

  // Basys3 button positions within the btn_* vectors
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int DEB_CNT_BITS       = 20;
  localparam int DEB_STABLE_SAMPLES = 4;

  typedef enum logic [0:0] {
    DEB_STABLE    = 1'b0,
    DEB_CANDIDATE = 1'b1
  } deb_state_t;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-FF synchroniser, tick-sampled qualification FSM,
// debounced level and registered press/release pulses.
module debounce_cell import btn_pkg::*; #(
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES,
  parameter int CW             = $clog2(STABLE_SAMPLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  logic          sync1_q, sync2_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // cnt never exceeds STABLE_SAMPLES-1, so the increment always fits in CW bits
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick_i) begin
      case (state_q)
        DEB_STABLE: begin
          if (sync2_q != level_q) begin
            if (STABLE_SAMPLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = DEB_CANDIDATE;
              cnt_d   = CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        DEB_CANDIDATE: begin
          if (sync2_q != level_q) begin
            if (cnt_inc == CW'(STABLE_SAMPLES)) accept = 1'b1;
            else                                 cnt_d  = cnt_inc;
          end else begin
            // bounced back before qualifying: drop the candidate silently
            state_d = DEB_STABLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = DEB_STABLE;
          cnt_d   = '0;
        end
      endcase
      if (accept) begin
        state_d = DEB_STABLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (accept) begin
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DEB_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: derives the sample tick from the MSB
// wrap of the shared refresh counter and fans it out to per-channel cells.
module btn_debounce import btn_pkg::*; #(
  parameter int N_BTN          = 5,
  parameter int CNT_BITS       = DEB_CNT_BITS,
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES   // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_BITS-1:0] cnt_q,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic [N_BTN-1:0]    btn_release
);

  logic msb_d;
  logic tick;
  logic cnt_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) msb_d <= 1'b0;
    else     msb_d <= cnt_q[CNT_BITS-1];
  end

  // falling MSB marks a full counter wrap; msb_d resets low so no tick right after reset
  assign tick       = msb_d & ~cnt_q[CNT_BITS-1];
  assign cnt_unused = ^cnt_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .raw_i    (btn_raw[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

endmodule
